// File: rtl/pcileech_sysrst_seq.sv
// Board reset sequencer: core/FT601 reset, PCIe core reset from filtered PERST#/PRSNT,
// WAKE# pulse generator and power-on LED blink, all in the clk domain.
module pcileech_sysrst_seq #(
  parameter int RST_CYCLES    = 64,
  parameter int FILT_CYCLES   = 16,
  parameter int WAKE_CYCLES   = 1024,
  parameter int BLINK_BIT     = 24,
  parameter int BLINK_END_BIT = 27
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pcie_perst_n,
  input  logic       pcie_present,
  input  logic       wake_req,
  output logic       rst,
  output logic       ft601_rst_n,
  output logic       pcie_rst,
  output logic       pcie_wake_n,
  output logic       led_pwronblink,
  output logic [7:0] perst_events
);

  localparam int RCW = $clog2(RST_CYCLES);
  localparam int FCW = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
  localparam int WCW = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
  localparam int TW  = BLINK_END_BIT + 1;

  typedef enum logic [1:0] {
    ST_POR      = 2'd0,
    ST_LINK_RST = 2'd1,
    ST_RUN      = 2'd2
  } state_e;

  // Glitch filter step: returns {filtered, counter}; a change is accepted only after
  // FILT_CYCLES consecutive differing samples.
  function automatic logic [FCW:0] filt_next(input logic s, input logic f,
                                             input logic [FCW-1:0] cnt);
    logic [FCW:0] r;
    if (s == f) begin
      r = {f, {FCW{1'b0}}};
    end else if (cnt == FCW'(FILT_CYCLES - 1)) begin
      r = {s, {FCW{1'b0}}};
    end else begin
      r = {f, cnt + FCW'(1)};
    end
    return r;
  endfunction

  state_e           state_q, state_d;
  logic [1:0]       rst_sync_q, rst_sync_d;
  logic [1:0]       perst_sync_q, perst_sync_d;
  logic [1:0]       prsnt_sync_q, prsnt_sync_d;
  logic             perst_f_q, perst_f_d;
  logic             prsnt_f_q, prsnt_f_d;
  logic [FCW-1:0]   perst_cnt_q, perst_cnt_d;
  logic [FCW-1:0]   prsnt_cnt_q, prsnt_cnt_d;
  logic [RCW-1:0]   por_cnt_q, por_cnt_d;
  logic             wake_req_q, wake_req_d;
  logic             wake_prev_q, wake_prev_d;
  logic             wake_act_q, wake_act_d;
  logic [WCW-1:0]   wake_cnt_q, wake_cnt_d;
  logic [TW-1:0]    tick_q, tick_d;
  logic             rst_q, rst_d;
  logic             ft601_rst_n_q, ft601_rst_n_d;
  logic             pcie_rst_q, pcie_rst_d;
  logic             pcie_wake_n_q, pcie_wake_n_d;
  logic             led_q, led_d;
  logic [7:0]       perst_events_q, perst_events_d;
  logic             rst_ok_s;
  logic             wake_rise_s;
  logic             wake_ok_s;

  assign rst_ok_s    = rst_sync_q[1];
  assign wake_rise_s = wake_req_q & ~wake_prev_q;
  assign wake_ok_s   = (state_q == ST_LINK_RST) & prsnt_f_q & ~perst_f_q;

  // Reset release synchroniser; all other state is held at reset until it completes.
  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_POR;
    end else if (!rst_ok_s) begin
      state_q <= ST_POR;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    por_cnt_d = por_cnt_q;
    case (state_q)
      ST_POR: begin
        if (por_cnt_q == RCW'(RST_CYCLES - 1)) begin
          state_d   = ST_LINK_RST;
          por_cnt_d = {RCW{1'b0}};
        end else begin
          state_d   = ST_POR;
          por_cnt_d = por_cnt_q + RCW'(1);
        end
      end
      ST_LINK_RST: begin
        if (perst_f_q && prsnt_f_q) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_LINK_RST;
        end
      end
      ST_RUN: begin
        if (!perst_f_q || !prsnt_f_q) begin
          state_d = ST_LINK_RST;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d   = ST_POR;
        por_cnt_d = {RCW{1'b0}};
      end
    endcase
  end

  // Outputs decode the next state so they move on the same edge as the state register.
  always_comb begin
    rst_d         = (state_d == ST_POR);
    ft601_rst_n_d = (state_d != ST_POR);
    pcie_rst_d    = (state_d != ST_RUN);

    if ((state_q == ST_RUN) && (state_d == ST_LINK_RST) && (perst_events_q != 8'hFF)) begin
      perst_events_d = perst_events_q + 8'd1;
    end else begin
      perst_events_d = perst_events_q;
    end

    perst_sync_d = {perst_sync_q[0], pcie_perst_n};
    prsnt_sync_d = {prsnt_sync_q[0], pcie_present};
    {perst_f_d, perst_cnt_d} = filt_next(perst_sync_q[1], perst_f_q, perst_cnt_q);
    {prsnt_f_d, prsnt_cnt_d} = filt_next(prsnt_sync_q[1], prsnt_f_q, prsnt_cnt_q);

    wake_req_d  = wake_req;
    wake_prev_d = wake_req_q;
    if (wake_act_q) begin
      if (perst_f_q || !prsnt_f_q || (wake_cnt_q == WCW'(WAKE_CYCLES - 1))) begin
        wake_act_d = 1'b0;
        wake_cnt_d = {WCW{1'b0}};
      end else begin
        wake_act_d = 1'b1;
        wake_cnt_d = wake_cnt_q + WCW'(1);
      end
    end else if (wake_rise_s && wake_ok_s) begin
      wake_act_d = 1'b1;
      wake_cnt_d = {WCW{1'b0}};
    end else begin
      wake_act_d = 1'b0;
      wake_cnt_d = {WCW{1'b0}};
    end
    pcie_wake_n_d = ~wake_act_d;

    if (tick_q[BLINK_END_BIT]) begin
      tick_d = tick_q;
    end else begin
      tick_d = tick_q + TW'(1);
    end
    led_d = tick_d[BLINK_BIT] & ~tick_d[BLINK_END_BIT];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      por_cnt_q      <= {RCW{1'b0}};
      perst_sync_q   <= 2'b00;
      prsnt_sync_q   <= 2'b00;
      perst_f_q      <= 1'b0;
      prsnt_f_q      <= 1'b0;
      perst_cnt_q    <= {FCW{1'b0}};
      prsnt_cnt_q    <= {FCW{1'b0}};
      wake_req_q     <= 1'b0;
      wake_prev_q    <= 1'b0;
      wake_act_q     <= 1'b0;
      wake_cnt_q     <= {WCW{1'b0}};
      tick_q         <= {TW{1'b0}};
      rst_q          <= 1'b1;
      ft601_rst_n_q  <= 1'b0;
      pcie_rst_q     <= 1'b1;
      pcie_wake_n_q  <= 1'b1;
      led_q          <= 1'b0;
      perst_events_q <= 8'd0;
    end else if (!rst_ok_s) begin
      por_cnt_q      <= {RCW{1'b0}};
      perst_sync_q   <= 2'b00;
      prsnt_sync_q   <= 2'b00;
      perst_f_q      <= 1'b0;
      prsnt_f_q      <= 1'b0;
      perst_cnt_q    <= {FCW{1'b0}};
      prsnt_cnt_q    <= {FCW{1'b0}};
      wake_req_q     <= 1'b0;
      wake_prev_q    <= 1'b0;
      wake_act_q     <= 1'b0;
      wake_cnt_q     <= {WCW{1'b0}};
      tick_q         <= {TW{1'b0}};
      rst_q          <= 1'b1;
      ft601_rst_n_q  <= 1'b0;
      pcie_rst_q     <= 1'b1;
      pcie_wake_n_q  <= 1'b1;
      led_q          <= 1'b0;
      perst_events_q <= 8'd0;
    end else begin
      por_cnt_q      <= por_cnt_d;
      perst_sync_q   <= perst_sync_d;
      prsnt_sync_q   <= prsnt_sync_d;
      perst_f_q      <= perst_f_d;
      prsnt_f_q      <= prsnt_f_d;
      perst_cnt_q    <= perst_cnt_d;
      prsnt_cnt_q    <= prsnt_cnt_d;
      wake_req_q     <= wake_req_d;
      wake_prev_q    <= wake_prev_d;
      wake_act_q     <= wake_act_d;
      wake_cnt_q     <= wake_cnt_d;
      tick_q         <= tick_d;
      rst_q          <= rst_d;
      ft601_rst_n_q  <= ft601_rst_n_d;
      pcie_rst_q     <= pcie_rst_d;
      pcie_wake_n_q  <= pcie_wake_n_d;
      led_q          <= led_d;
      perst_events_q <= perst_events_d;
    end
  end

  assign rst            = rst_q;
  assign ft601_rst_n    = ft601_rst_n_q;
  assign pcie_rst       = pcie_rst_q;
  assign pcie_wake_n    = pcie_wake_n_q;
  assign led_pwronblink = led_q;
  assign perst_events   = perst_events_q;

endmodule

// File: tb/tb_pcileech_sysrst_seq.sv
// Scoreboard bench for pcileech_sysrst_seq: a per-edge reference model queues expected
// outputs, a negedge monitor pops and compares them against the DUT.
module tb_pcileech_sysrst_seq;

  localparam int RST   = 8;
  localparam int FILT  = 4;
  localparam int WAKE  = 5;
  localparam int BB    = 2;
  localparam int BE    = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       perst_n;
  logic       present;
  logic       wake_req;
  logic       rst;
  logic       ft601_rst_n;
  logic       pcie_rst;
  logic       pcie_wake_n;
  logic       led_pwronblink;
  logic [7:0] perst_events;

  pcileech_sysrst_seq #(
    .RST_CYCLES(RST), .FILT_CYCLES(FILT), .WAKE_CYCLES(WAKE),
    .BLINK_BIT(BB), .BLINK_END_BIT(BE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pcie_perst_n(perst_n), .pcie_present(present),
    .wake_req(wake_req), .rst(rst), .ft601_rst_n(ft601_rst_n), .pcie_rst(pcie_rst),
    .pcie_wake_n(pcie_wake_n), .led_pwronblink(led_pwronblink), .perst_events(perst_events)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic       ft;
    logic       prst;
    logic       wn;
    logic       led;
    logic [7:0] ev;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t reset_exp();
    exp_t e;
    e.rst = 1'b1; e.ft = 1'b0; e.prst = 1'b1; e.wn = 1'b1; e.led = 1'b0; e.ev = 8'd0;
    return e;
  endfunction

  task automatic chk(input string nm, input int act, input int expv);
    checks = checks + 1;
    if (act != expv) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  // Reference model: expectations from the edge index since reset release.
  int   rel = 0;
  int   j;
  bit   m_pf, m_rf, m_run;
  int   m_ev, m_low, tk, k0;
  bit   opf, orf, was_run, por_before, link_before, rise, ok;
  bit   pp_pad[$], pr_pad[$], wq[$], pp_s[$], pr_s[$];
  exp_t me;

  always @(posedge clk) begin
    if (!rst_n) begin
      rel = 0; m_pf = 1'b0; m_rf = 1'b0; m_run = 1'b0; m_ev = 0; m_low = 0;
      pp_pad.delete(); pr_pad.delete(); wq.delete(); pp_s.delete(); pr_s.delete();
      me = reset_exp();
    end else begin
      rel = rel + 1;
      if (rel <= 2) begin
        me = reset_exp();
      end else begin
        j = rel - 3;
        pp_pad.push_back(perst_n);
        pr_pad.push_back(present);
        wq.push_back(wake_req);
        pp_s.push_back((j >= 2) ? pp_pad[j-2] : 1'b0);
        pr_s.push_back((j >= 2) ? pr_pad[j-2] : 1'b0);
        opf = m_pf; orf = m_rf; was_run = m_run;
        por_before = (j <= RST - 1);
        if (j == RST - 1) m_run = 1'b0;
        else if (j > RST - 1) m_run = opf && orf;
        if (was_run && !m_run && m_ev < 255) m_ev = m_ev + 1;
        rise = ((j >= 1) ? wq[j-1] : 1'b0) && !((j >= 2) ? wq[j-2] : 1'b0);
        link_before = !por_before && !was_run;
        if (m_low > 0) begin
          if (opf || !orf) m_low = 0;
          else m_low = m_low - 1;
        end else if (rise && link_before && orf && !opf) begin
          m_low = WAKE;
        end
        // A filtered value flips once the last FILT synced samples all disagree with it.
        k0 = (j - FILT + 1 < 0) ? 0 : j - FILT + 1;
        ok = (j >= FILT - 1);
        for (int k = k0; k <= j; k++) if (ok && pp_s[k] == m_pf) ok = 1'b0;
        if (ok) m_pf = !m_pf;
        ok = (j >= FILT - 1);
        for (int k = k0; k <= j; k++) if (ok && pr_s[k] == m_rf) ok = 1'b0;
        if (ok) m_rf = !m_rf;
        tk = (j + 1 < (1 << BE)) ? j + 1 : (1 << BE);
        me.rst  = (j < RST - 1);
        me.ft   = !(j < RST - 1);
        me.prst = !m_run;
        me.wn   = (m_low == 0);
        me.led  = (tk < (1 << BE)) ? 1'(((tk >> BB) & 1)) : 1'b0;
        me.ev   = 8'(m_ev);
      end
    end
    exp_q.push_back(me);
  end

  // Async reset invalidates anything already queued for the current cycle.
  always @(negedge rst_n) begin
    foreach (exp_q[i]) exp_q[i] = reset_exp();
  end

  exp_t got;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      got = exp_q.pop_front();
      chk("rst",          int'(rst),            int'(got.rst));
      chk("ft601_rst_n",  int'(ft601_rst_n),    int'(got.ft));
      chk("pcie_rst",     int'(pcie_rst),       int'(got.prst));
      chk("pcie_wake_n",  int'(pcie_wake_n),    int'(got.wn));
      chk("led_blink",    int'(led_pwronblink), int'(got.led));
      chk("perst_events", int'(perst_events),   int'(got.ev));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic async_reset_check(input string tag);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk({tag, "_rst"},          int'(rst),            1);
    chk({tag, "_ft601_rst_n"},  int'(ft601_rst_n),    0);
    chk({tag, "_pcie_rst"},     int'(pcie_rst),       1);
    chk({tag, "_pcie_wake_n"},  int'(pcie_wake_n),    1);
    chk({tag, "_led"},          int'(led_pwronblink), 0);
    chk({tag, "_perst_events"}, int'(perst_events),   0);
    @(negedge clk);
    cyc(2);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; perst_n = 1'b1; present = 1'b1; wake_req = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(RST + 1);
    chk("rst_held_edge9", int'(rst), 1);
    cyc(1);
    chk("rst_fall_edge10", int'(rst), 0);
    chk("ft601_rise_edge10", int'(ft601_rst_n), 1);
    cyc(40);

    // PERST# glitch shorter than the filter, then a real assertion.
    perst_n = 1'b0; cyc(3); perst_n = 1'b1; cyc(10);
    perst_n = 1'b0; cyc($urandom_range(4, 8)); perst_n = 1'b1; cyc(15);

    // Wake pulse in LINK_RST, double edge during pulse, and held request.
    perst_n = 1'b0; cyc(10);
    wake_req = 1'b1; cyc($urandom_range(2, 8)); wake_req = 1'b0; cyc(10);
    wake_req = 1'b1; cyc(1); wake_req = 1'b0; cyc(1); wake_req = 1'b1; cyc(12);
    wake_req = 1'b0; cyc(3);
    // PERST# deasserting just before the wake edge aborts the pulse.
    for (int r = 0; r < 3; r++) begin
      perst_n = 1'b1; cyc($urandom_range(1, 3));
      wake_req = 1'b1; cyc(8); wake_req = 1'b0; perst_n = 1'b0; cyc(12);
    end

    // Wake edges in RUN and with PRSNT low are dropped.
    perst_n = 1'b1; present = 1'b1; cyc(12);
    wake_req = 1'b1; cyc(3); wake_req = 1'b0; cyc(5);
    perst_n = 1'b0; present = 1'b0; cyc(10);
    wake_req = 1'b1; cyc(3); wake_req = 1'b0; cyc(8);

    // Async reset in RUN, then a simultaneous PERST#/PRSNT fall counts once.
    perst_n = 1'b1; present = 1'b1; cyc(12);
    async_reset_check("mid_run");
    cyc(40);
    perst_n = 1'b0; present = 1'b0; cyc(12);
    chk("simul_fall_events", int'(perst_events), 1);

    // Async reset during an active wake pulse.
    present = 1'b1; cyc(10);
    wake_req = 1'b1; cyc(3);
    async_reset_check("mid_wake");
    wake_req = 1'b0;
    cyc(40);

    // Randomised pad and wake activity.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 15) == 0) perst_n = ~perst_n;
      if ($urandom_range(0, 39) == 0) present = ~present;
      if ($urandom_range(0, 7) == 0) wake_req = ~wake_req;
      cyc(1);
    end

    // Event counter saturation.
    perst_n = 1'b1; present = 1'b1; wake_req = 1'b0; cyc(12);
    for (int p = 0; p < 300; p++) begin
      perst_n = 1'b0; cyc(10);
      perst_n = 1'b1; cyc($urandom_range(8, 14));
    end
    chk("events_saturated", int'(perst_events), 255);
    chk("rst_low_after_pulses", int'(rst), 0);
    cyc(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pcileech_sysrst_seq.md
# pcileech_sysrst_seq

System reset and PCIe sideband sequencer for the x1 Artix-7 boards. It replaces the free-running tick-count reset in the board top level. It produces the core `rst` consumed by the FIFO, COM and PCIe blocks, the FT601 reset, a PCIe-core reset derived from filtered PERST#/PRSNT, the power-on LED blink, and a WAKE# pulse generator. It sits between the board pads and `pcileech_fifo` / `pcileech_pcie_a7`.

## Interface
Parameters:
- RST_CYCLES, 64: clocks `rst` is held after `rst_n` deasserts (≥2).
- FILT_CYCLES, 16: consecutive stable synced samples required before a PERST#/PRSNT change is accepted (≥1).
- WAKE_CYCLES, 1024: WAKE# low-pulse length in clocks (≥1).
- BLINK_BIT, 24: tick bit driving the power-on blink.
- BLINK_END_BIT, 27: blink stops once tick reaches 2^BLINK_END_BIT (> BLINK_BIT).

Ports:
- clk  in  1  system clock, 100 MHz; all logic in this domain.
- rst_n  in  1  asynchronous active-low reset; asserts immediately, deassertion synchronised internally with 2 flops.
- pcie_perst_n  in  1  PERST# pad, asynchronous to clk.
- pcie_present  in  1  PRSNT pad, active-high, asynchronous to clk.
- wake_req  in  1  level request from FIFO control; rising edge arms a wake pulse.
- rst  out  1  core reset, active-high.
- ft601_rst_n  out  1  equals ~rst, registered.
- pcie_rst  out  1  PCIe core reset, active-high.
- pcie_wake_n  out  1  WAKE# drive, active-low.
- led_pwronblink  out  1  power-on blink for `led_state_invert`.
- perst_events  out  8  saturating count of RUN→LINK_RST transitions.

## Operation
- Reset values: rst=1, ft601_rst_n=0, pcie_rst=1, pcie_wake_n=1, led_pwronblink=0, perst_events=0. State=POR, filtered perst=0, filtered present=0, all counters 0.
- Input conditioning, per input: 2-flop synchroniser, then filter.
  - Filter counter clears when synced value equals filtered value; otherwise it increments.
  - The edge on which the counter would reach FILT_CYCLES loads the filtered value from synced and clears the counter.
  - A glitch shorter than FILT_CYCLES never changes the filtered value.
- States:
  - POR: rst=1, pcie_rst=1. The counter runs 0..RST_CYCLES-1. On reaching RST_CYCLES-1 → LINK_RST.
  - LINK_RST: rst=0, pcie_rst=1. If present_f=1 and perst_f=1 → RUN.
  - RUN: rst=0, pcie_rst=0. If perst_f=0 or present_f=0 → LINK_RST and perst_events+1, saturating at 255.
- All outputs are registered from next-state decode and change on the same edge as the state.
- Wake:
  - Armed on a wake_req 0→1 edge (registered previous value) only when state=LINK_RST, present_f=1, perst_f=0 and no pulse is active. Otherwise the edge is dropped.
  - Active: pcie_wake_n=0 for exactly WAKE_CYCLES clocks, then 1.
  - perst_f becoming 1 or present_f becoming 0 aborts the pulse: pcie_wake_n=1 on the next edge.
- Blink:
  - Tick counter is BLINK_END_BIT+1 bits, increments every clock, and stops at 2^BLINK_END_BIT.
  - led_pwronblink = tick[BLINK_BIT] while tick < 2^BLINK_END_BIT, else 0 permanently.
- Asynchronous rst_n assertion in any state: every output returns to its reset value without waiting for a clock edge. The sequence restarts from POR.

## Timing
- rst deasserts RST_CYCLES+2 edges after rst_n deasserts: 2 synchroniser edges plus RST_CYCLES counting edges. ft601_rst_n rises on the same edge.
- PERST#/PRSNT latency: counting the first edge that samples the new pad value as edge 1, the filtered value updates at edge FILT_CYCLES+2. pcie_rst changes at edge FILT_CYCLES+3.
- Simultaneous perst_f fall and present_f fall: one transition, perst_events +1 only.
- Pad already high at reset release: RUN is entered no earlier than 1 edge after POR exits, and only once the filters have accepted the high values.
- Wake pulse: pcie_wake_n falls 1 edge after the edge that registers wake_req=1 and stays low for WAKE_CYCLES edges.
- A second wake_req edge during a pulse is ignored. wake_req held high does not re-arm.

## Test plan
Parameters for all scenarios: RST_CYCLES=8, FILT_CYCLES=4, WAKE_CYCLES=5, BLINK_BIT=2, BLINK_END_BIT=5.
- Power-up, pads high: release rst_n → rst falls at edge 10; pcie_rst falls once filters settle; led_pwronblink toggles every 4 clocks, then stays 0 from tick 32.
- PERST# glitch of 3 clocks low in RUN → no change. PERST# low for 4+ clocks → pcie_rst=1 at edge 7 counted from first low sample; perst_events=1.
- 300 PERST# low pulses of 10 clocks → perst_events saturates at 255; rst stays 0 throughout.
- LINK_RST with present=1, perst=0, wake_req 0→1 → pcie_wake_n low exactly 5 clocks. Repeat with perst_n rising mid-pulse → pulse aborted, pcie_wake_n=1.
- wake_req edge while in RUN, or with present=0 → pcie_wake_n stays 1.
- rst_n asserted mid-RUN and mid-wake-pulse → rst=1, pcie_rst=1, pcie_wake_n=1, perst_events=0 immediately, before the next clk edge; full sequence repeats on release.
